lfsr_stream_decryptor: RTL and testbench
========================================

// Module: lfsr_stream_decryptor
// PURPOSE
//  Hardware successor to the program-3 software decrypter. Consumes a stream of
//  MSG_WORDS encrypted words, each {parity, W-bit cipher}, and recovers the
//  LFSR tap pattern and seed from the known space preamble (space-0x20 = 0).
//  Emits the plaintext with preamble and leading spaces stripped. Plaintext is
//  offset by -0x20 and carries an error flag in its MSB.
//  Sits between the data-memory read port and the result write-back path.
// PARAMETERS
//  W          7         LFSR and character width (plaintext is char-0x20)
//  NPAT       9         number of candidate maximal-length tap patterns
//  TAPS       {7'h60,7'h48,7'h78,7'h72,7'h6A,7'h69,7'h5C,7'h7E,7'h7B}
//                       packed NPAT*W; index 0 = leftmost entry
//  PRE_MIN    10        guaranteed-clean preamble words used for discovery (>=3)
//  MAX_LEAD   24        word index at which space stripping ends unconditionally
//  MSG_WORDS  64        encrypted words per message
//  PARITY_EN  1         1: bit W is even parity of bits [W-1:0]; 0: bit W ignored
// PORTS
//  clk        in   1        single clock, rising edge
//  init_n     in   1        asynchronous reset, active low
//  req        in   1        start pulse; sampled only in IDLE/DONE
//  ack        out  1        message complete; held until next req or reset
//  in_valid   in   1        cipher word valid
//  in_ready   out  1        engine accepts cipher word this cycle
//  in_data    in   W+1      {parity, cipher}
//  out_valid  out  1        plaintext word valid
//  out_ready  in   1        sink accepts plaintext word
//  out_data   out  W+1      {err, plain-0x20}; err=1 -> parity failed, payload raw
//  pat_idx    out  log2(NPAT) selected tap index (valid when ack and !no_match)
//  no_match   out  1        no candidate fits preamble, or seed was zero
//  out_cnt    out  7        plaintext words emitted this message
// BEHAVIOUR
//  Reset: ack=0, in_ready=0, out_valid=0, out_data=0, pat_idx=0, no_match=0, out_cnt=0.
//  State is IDLE. Reset asserted mid-message aborts cleanly; no partial ack.
//  next(s,t) = {s[W-2:0], ^(s & t)}. Transfers occur on valid&&ready.
//  IDLE/DONE: req=1 clears counters, survive=all-ones, ack, no_match -> DISC.
//  DISC: in_ready=1. Word 0: seed=in_data[W-1:0]; zero seed -> no_match.
//   Word k (1..PRE_MIN-1): survive[p] &= (next(prev,TAPS[p]) == in_data[W-1:0]).
//   Parity bit ignored during DISC.
//   On word PRE_MIN-1: pat_idx = lowest surviving p, lfsr = next(word, TAPS[p]).
//   Go to STRIP. If none survive or seed was zero: no_match=1, go to DONE.
//   Remaining input is not consumed; the upstream flushes it.
//  STRIP/PASS: in_ready = !out_valid || out_ready (one-entry output register).
//   Per accepted word: plain = cipher ^ lfsr; err = PARITY_EN && (^in_data != 0).
//   lfsr advances once per accepted word, independent of drop/emit or err.
//  STRIP: a word with plain==0, err==0 and word index < MAX_LEAD is dropped.
//   Anything else is emitted and causes the transition to PASS.
//  PASS: every word is emitted.
//  Emit: out_data registered one cycle after acceptance; out_cnt increments on
//   the output handshake. Back-to-back throughput is 1 word/cycle while out_ready=1.
//  Once MSG_WORDS words are accepted and the output register has drained:
//   go to DONE with ack=1. Input accepted in DONE is ignored (in_ready=0).
//  Word index counts 0..MSG_WORDS-1 and never wraps within a message.
//  Simultaneous out handshake and new accept in the same cycle is legal; no bubble.
//  out_valid is held stable with out_data unchanged until out_ready.
// TESTING
//  1 TAPS[7]=0x7E, seed 0x36, pre_length 10, "  0123..." padded to 64 -> first
//    cipher words 0x36,0x6C; pat_idx=7, 52 words out, first out_data=0x10 ('0').
//  2 Same message with bit 2 flipped in word 30 -> out_data for that word has
//    MSB=1; all other words correct; lfsr stays in sync (next word decrypts).
//  3 Garbage preamble (word 3 altered) -> no_match=1, ack=1, out_cnt=0.
//  4 Message of all spaces -> stripping stops at index 24; 40 words out, all 0x00.
//  5 out_ready toggled 1/0 every cycle during PASS -> no drop or duplicate, out_cnt=52.
//  6 init_n pulsed low at word 40, then req -> clean rerun matches scenario 1.

Source files
------------

// File: rtl/lfsr_stream_decryptor_if.sv
// rtl/lfsr_stream_decryptor_if.sv - control and stream bundle for the LFSR stream decryptor
// Purpose: groups the start/done handshake, the cipher input stream, the
//          plaintext output stream and the result status of the decryptor.
// Signals: req/ack          start pulse / message complete
//          in_valid/in_ready/in_data     cipher stream {parity, cipher}
//          out_valid/out_ready/out_data  plaintext stream {err, plain-0x20}
//          pat_idx/no_match/out_cnt      discovery result and emitted count
// Modports: slave = decryptor side, master = environment side.

interface lfsr_stream_decryptor_if #(
    parameter int W    = 7,
    parameter int NPAT = 9
) ();
    localparam int PW = (NPAT > 1) ? $clog2(NPAT) : 1;

    logic          req;
    logic          ack;
    logic          in_valid;
    logic          in_ready;
    logic [W:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    out_data;
    logic [PW-1:0] pat_idx;
    logic          no_match;
    logic [6:0]    out_cnt;

    modport slave (
        input  req, in_valid, in_data, out_ready,
        output ack, in_ready, out_valid, out_data, pat_idx, no_match, out_cnt
    );

    modport master (
        output req, in_valid, in_data, out_ready,
        input  ack, in_ready, out_valid, out_data, pat_idx, no_match, out_cnt
    );
endinterface

// File: rtl/lfsr_stream_decryptor.sv
// rtl/lfsr_stream_decryptor.sv - LFSR tap/seed discovery and stream decryption engine
// Purpose: learns the LFSR seed and tap pattern from the all-space preamble of
//          an encrypted message, then decrypts the rest of the message,
//          stripping leading spaces and flagging parity errors.
// Ports:   clk     rising-edge clock
//          init_n  asynchronous active-low reset
//          bus     lfsr_stream_decryptor_if.slave (req/ack, cipher stream,
//                  plaintext stream, pat_idx/no_match/out_cnt status)

module lfsr_stream_decryptor #(
    parameter int               W         = 7,
    parameter int               NPAT      = 9,
    parameter logic [NPAT*W-1:0] TAPS     = {7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                             7'h69, 7'h5C, 7'h7E, 7'h7B},
    parameter int               PRE_MIN   = 10,
    parameter int               MAX_LEAD  = 24,
    parameter int               MSG_WORDS = 64,
    parameter int               PARITY_EN = 1
) (
    input logic                   clk,
    input logic                   init_n,
    lfsr_stream_decryptor_if.slave bus
);
    localparam int PW = (NPAT > 1) ? $clog2(NPAT) : 1;
    localparam int IW = $clog2(MSG_WORDS + 1);

    localparam logic [IW-1:0] C_PRE_LAST = IW'(PRE_MIN - 1);
    localparam logic [IW-1:0] C_MAX_LEAD = IW'(MAX_LEAD);
    localparam logic [IW-1:0] C_MSG      = IW'(MSG_WORDS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DISC  = 3'd1;
    localparam logic [2:0] S_STRIP = 3'd2;
    localparam logic [2:0] S_PASS  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [W-1:0] f_next(input logic [W-1:0] s, input logic [W-1:0] t);
        return {s[W-2:0], ^(s & t)};
    endfunction

    logic [2:0]      r_state;
    logic [NPAT-1:0] r_survive;
    logic [W-1:0]    r_prev;
    logic [W-1:0]    r_lfsr;
    logic [W-1:0]    r_tap;
    logic [IW-1:0]   r_idx;
    logic            r_seed_zero;
    logic            r_out_valid;
    logic [W:0]      r_out_data;
    logic [PW-1:0]   r_pat_idx;
    logic            r_no_match;
    logic [6:0]      r_out_cnt;
    logic            r_ack;

    logic            w_in_ready;
    logic            w_xfer_in;
    logic            w_xfer_out;
    logic [W-1:0]    w_cipher;
    logic [W-1:0]    w_plain;
    logic            w_err;
    logic            w_drop;
    logic [NPAT-1:0] w_match;
    logic [NPAT-1:0] w_survive_nx;
    logic            w_found;
    logic [PW-1:0]   w_sel;
    logic [W-1:0]    w_sel_tap;

    assign w_cipher   = bus.in_data[W-1:0];
    assign w_plain    = w_cipher ^ r_lfsr;
    // Even parity over the whole word: any odd count of ones is an error.
    assign w_err      = (PARITY_EN != 0) && (^bus.in_data);
    assign w_xfer_in  = bus.in_valid && w_in_ready;
    assign w_xfer_out = r_out_valid && bus.out_ready;
    assign w_drop     = (r_state == S_STRIP) && (w_plain == '0) && !w_err
                        && (r_idx < C_MAX_LEAD);

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_DISC:          w_in_ready = 1'b1;
            // One-entry output register: accept only if it is empty or draining.
            S_STRIP, S_PASS: w_in_ready = (r_idx < C_MSG) && (!r_out_valid || bus.out_ready);
            default:         w_in_ready = 1'b0;
        endcase
    end

    // Every candidate predicts the next preamble word from the previous one.
    always_comb begin
        w_match = '0;
        for (int p = 0; p < NPAT; p++) begin
            w_match[p] = (f_next(r_prev, TAPS[(NPAT-1-p)*W +: W]) == w_cipher);
        end
    end

    assign w_survive_nx = r_survive & w_match;

    // Lowest-index survivor wins; scan downwards so the last hit is the lowest.
    always_comb begin
        w_found   = 1'b0;
        w_sel     = '0;
        w_sel_tap = '0;
        for (int p = NPAT - 1; p >= 0; p--) begin
            if (w_survive_nx[p]) begin
                w_found   = 1'b1;
                w_sel     = PW'(p);
                w_sel_tap = TAPS[(NPAT-1-p)*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state     <= S_IDLE;
            r_survive   <= '1;
            r_prev      <= '0;
            r_lfsr      <= '0;
            r_tap       <= '0;
            r_idx       <= '0;
            r_seed_zero <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_pat_idx   <= '0;
            r_no_match  <= 1'b0;
            r_out_cnt   <= '0;
            r_ack       <= 1'b0;
        end else begin
            if (w_xfer_out) begin
                r_out_valid <= 1'b0;
                r_out_cnt   <= r_out_cnt + 7'd1;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.req) begin
                        r_idx       <= '0;
                        r_out_cnt   <= '0;
                        r_survive   <= '1;
                        r_ack       <= 1'b0;
                        r_no_match  <= 1'b0;
                        r_seed_zero <= 1'b0;
                        r_state     <= S_DISC;
                    end
                end
                S_DISC: begin
                    if (w_xfer_in) begin
                        r_prev <= w_cipher;
                        r_idx  <= r_idx + 1'b1;
                        if (r_idx == '0) begin
                            r_seed_zero <= (w_cipher == '0);
                        end else begin
                            r_survive <= w_survive_nx;
                            if (r_idx == C_PRE_LAST) begin
                                if (!w_found || r_seed_zero) begin
                                    r_no_match <= 1'b1;
                                    r_ack      <= 1'b1;
                                    r_state    <= S_DONE;
                                end else begin
                                    r_pat_idx <= w_sel;
                                    r_tap     <= w_sel_tap;
                                    r_lfsr    <= f_next(w_cipher, w_sel_tap);
                                    r_state   <= S_STRIP;
                                end
                            end
                        end
                    end
                end
                S_STRIP, S_PASS: begin
                    if (w_xfer_in) begin
                        r_idx  <= r_idx + 1'b1;
                        // Keystream advances on every accepted word, dropped or not.
                        r_lfsr <= f_next(r_lfsr, r_tap);
                        if (!w_drop) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= {w_err, w_plain};
                            r_state     <= S_PASS;
                        end
                    end else if ((r_idx == C_MSG) && !r_out_valid) begin
                        r_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack       = r_ack;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.pat_idx   = r_pat_idx;
    assign bus.no_match  = r_no_match;
    assign bus.out_cnt   = r_out_cnt;
endmodule

// File: tb/tb_lfsr_stream_decryptor.sv
// tb/tb_lfsr_stream_decryptor.sv - scoreboard bench for the LFSR stream decryptor

module tb_lfsr_stream_decryptor;
    logic clk = 1'b0;
    logic init_n;
    always #5 clk = ~clk;

    lfsr_stream_decryptor_if #(.W(7), .NPAT(9)) bus ();

    lfsr_stream_decryptor dut (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] plain_chr [64];
    logic [7:0] cip       [64];
    int         err_word;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] lf_next(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    // kind 0: 12 spaces then "0123..." text; kind 1: all spaces. Tap 0x7E.
    task automatic build(input int kind, input logic [6:0] seed);
        logic [6:0] s;
        logic [6:0] c;
        s = seed;
        err_word = -1;
        for (int k = 0; k < 64; k++) begin
            if (kind == 0 && k >= 12) c = 7'(8'h10 + (k - 12) % 48);
            else                      c = 7'h00;
            plain_chr[k]  = c;
            cip[k][6:0]   = c ^ s;
            cip[k][7]     = ^(c ^ s);
            s = lf_next(s, 7'h7E);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_ack",       32'(bus.ack),       32'h0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data",  32'(bus.out_data),  32'h0);
        chk("rst_pat_idx",   32'(bus.pat_idx),   32'h0);
        chk("rst_no_match",  32'(bus.no_match),  32'h0);
        chk("rst_out_cnt",   32'(bus.out_cnt),   32'h0);
    endtask

    task automatic run_msg(input bit toggle, input int abort_at,
                           input int exp_cnt, input bit exp_nm, input int exp_pat);
        int         k;
        int         cyc;
        bit         done;
        bit         strip;
        bit         aborted;
        bit         hold;
        logic [7:0] hold_data;
        logic [7:0] e;
        k = 0; cyc = 0; done = 0; strip = 1; aborted = 0; hold = 0; hold_data = '0;
        exp_q.delete();
        @(negedge clk);
        bus.req = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        while (!done && cyc < 2000) begin
            if (abort_at >= 0 && k == abort_at) begin
                bus.in_valid = 1'b0;
                init_n = 1'b0;
                #1;
                check_reset_outputs();
                @(negedge clk);
                @(negedge clk);
                init_n = 1'b1;
                aborted = 1;
                break;
            end
            bus.in_valid  = (k < 64);
            bus.in_data   = (k < 64) ? cip[k] : 8'h00;
            bus.out_ready = toggle ? cyc[0] : 1'b1;
            #1;
            if (hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'h1);
                chk("hold_data",  32'(bus.out_data),  32'(hold_data));
            end
            hold = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_out", 32'(exp_q.size()), 32'h1);
                end else begin
                    e = exp_q.pop_front();
                    if (e[7]) chk("err_flag", 32'(bus.out_data[7]), 32'h1);
                    else      chk("out_data", 32'(bus.out_data), 32'(e));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (k >= 10) begin
                    if (k == err_word) begin
                        exp_q.push_back(8'h80);
                        strip = 0;
                    end else if (strip && plain_chr[k] == 7'h00 && k < 24) begin
                        // leading space dropped
                    end else begin
                        exp_q.push_back({1'b0, plain_chr[k]});
                        strip = 0;
                    end
                end
                k++;
            end
            @(negedge clk);
            cyc++;
            if (bus.ack) done = 1;
        end
        if (aborted) begin
            #1;
            chk("abort_ack", 32'(bus.ack), 32'h0);
        end else begin
            chk("ack_seen",     32'(done),          32'h1);
            chk("end_no_match", 32'(bus.no_match),  32'(exp_nm));
            chk("end_out_cnt",  32'(bus.out_cnt),   32'(exp_cnt));
            chk("sb_left",      32'(exp_q.size()),  32'h0);
            chk("end_in_ready", 32'(bus.in_ready),  32'h0);
            if (!exp_nm) chk("end_pat_idx", 32'(bus.pat_idx), 32'(exp_pat));
        end
    endtask

    initial begin
        init_n = 1'b0;
        bus.req = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        init_n = 1'b1;

        // 1: basic message, seed 0x36 with tap pattern 7
        build(0, 7'h36);
        chk("cipher_w0", 32'(cip[0][6:0]), 32'h36);
        chk("cipher_w1", 32'(cip[1][6:0]), 32'h6C);
        run_msg(1'b0, -1, 52, 1'b0, 7);

        // 2: bit 2 flipped in word 30, parity bit left alone
        build(0, 7'h36);
        cip[30][2] = ~cip[30][2];
        err_word = 30;
        run_msg(1'b0, -1, 52, 1'b0, 7);

        // 3: corrupted preamble word 3
        build(0, 7'h36);
        cip[3][0] = ~cip[3][0];
        run_msg(1'b0, -1, 0, 1'b1, 0);

        // 4: all spaces, stripping ends at index 24
        build(1, 7'h36);
        run_msg(1'b0, -1, 40, 1'b0, 7);

        // 5: output backpressure every other cycle
        build(0, 7'h36);
        run_msg(1'b1, -1, 52, 1'b0, 7);

        // 6: reset at word 40, then a clean rerun of scenario 1
        build(0, 7'h36);
        run_msg(1'b0, 40, 0, 1'b0, 0);
        run_msg(1'b0, -1, 52, 1'b0, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
